hamming_secded_dec_pipe: RTL and testbench
==========================================

Name: hamming_secded_dec_pipe

Overview:
- Parametrised, pipelined SECDED (extended Hamming) decoder. Successor to the 4-bit Hamming(7,4) decoder.
- Accepts codewords over a valid/ready stream and corrects single-bit errors. Flags double-bit errors.
- Keeps saturating error-event counters for system monitoring.
- Sits between the storage/link receive path and the consumer of the data words.

Parameters:
- DATA_W, 8, data bits per word; legal range 4..57.
- PAR_W, derived (not overridable), smallest r with 2^r >= DATA_W+r+1; 4 for DATA_W=8.
- CODE_W, derived, DATA_W+PAR_W+1; 13 for DATA_W=8.
- CNT_W, 16, width of each error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept a codeword this cycle.
- in_code  in  CODE_W  codeword.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  DATA_W  decoded (corrected if possible) data.
- out_err_single  out  1  single-bit error detected and corrected.
- out_err_double  out  1  uncorrectable error detected.
- out_syndrome  out  PAR_W  Hamming syndrome (error position, 0 = none in positions 1..CODE_W-1).
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_single  out  CNT_W  count of corrected words.
- cnt_double  out  CNT_W  count of uncorrectable words.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Codeword layout:
  - Vector bit i is Hamming position i.
  - Bit 0 is the overall even parity over bits CODE_W-1..1.
  - Power-of-two positions 1,2,4,... are parity bits.
  - Data bits fill the remaining positions in ascending order, d0 at position 3.
- Reset values:
  - in_ready=1 once reset is released; 0 while rst_n=0.
  - out_valid=0, out_data=0, out_err_single=0, out_err_double=0, out_syndrome=0.
  - cnt_single=0, cnt_double=0, all pipeline valid flags 0.
- Pipeline: 2 register stages.
  - S1 registers the codeword, syndrome and overall-parity result on acceptance (in_valid & in_ready).
  - S2 registers the corrected data and status, and drives the out_* ports.
  - Latency: accept in cycle N -> out_valid in cycle N+2 when out_ready=1 throughout.
  - Throughput: 1 word/cycle.
- Flow control:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 advances under the same condition.
  - in_ready = !s1_valid | s2_can_load.
  - No combinational path from in_valid to in_ready.
  - While out_valid=1 and out_ready=0, all out_* ports stay stable.
  - No word is dropped or duplicated under any valid/ready pattern.
- Classification (syndrome s, overall parity p = XOR of all CODE_W bits):
  - s=0, p=0: clean; both flags 0.
  - s!=0, p=1, s<=CODE_W-1: flip bit s; out_err_single=1.
  - s=0, p=1: error in bit 0; data unchanged; out_err_single=1.
  - s!=0, p=0: double error; out_err_double=1; data taken uncorrected.
  - s>CODE_W-1, p=1: out-of-range syndrome; out_err_double=1; data uncorrected.
  - out_err_single and out_err_double are never both 1.
- Counters:
  - Increment on the output handshake (out_valid & out_ready) of a flagged word.
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt=1 sets both counters to 0 next cycle. Clear wins over a simultaneous increment.
- Reset mid-operation: in-flight words are discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: HAMMING_ERR_INJECT_EN.
- Defined:
  - Adds port inj_mask  in  CODE_W.
  - inj_mask is XORed into in_code at acceptance, before S1 is registered. Used for in-system fault injection.
- Undefined:
  - Port absent; no XOR logic.
  - Behaviour otherwise identical.

Test Plan (DATA_W=8; data 0xA5 encodes to 0x144E):
- Reset with rst_n=0, then release -> all out_* and counters 0; in_ready=1 after release. Send 0x144E with out_ready=1 -> out_valid two cycles later, out_data=0xA5, both flags 0, out_syndrome=0.
- Send 0x146E (position 5 flipped) -> out_data=0xA5, out_err_single=1, out_syndrome=5, cnt_single=1.
- Send 0x1046 (positions 3 and 10 flipped) -> out_data=0x84, out_err_double=1, cnt_double=1.
- Send 0x144F (bit 0 flipped) -> out_data=0xA5, out_err_single=1, out_syndrome=0.
- Stream 6 back-to-back words with out_ready held 0 for 3 cycles mid-stream:
  - in_ready drops once both stages are full.
  - Outputs stay stable during the stall.
  - All 6 words arrive in order, none lost.
- Preload cnt_single to 0xFFFE, send 3 single-error words -> counter saturates at 0xFFFF. Assert clr_cnt in the same cycle as a flagged output handshake -> counter reads 0.
- With HAMMING_ERR_INJECT_EN defined: send 0x144E with inj_mask=0x0020 -> identical result to the 0x146E case.

Source files
------------

// File: rtl/hamming_secded_dec_pipe.sv
// Pipelined SECDED (extended Hamming) decoder with saturating error-event counters.
// Latency: a codeword accepted in cycle N appears on out_* in cycle N+2; throughput 1 word/cycle.
// Backpressure: a stalled output holds S2 stable, S1 fills behind it, and in_ready drops only when both stages are full.
//
// Optional build macro HAMMING_ERR_INJECT_EN adds port inj_mask, which is XORed into in_code
// at acceptance for in-system fault injection.
module hamming_secded_dec_pipe #(
    parameter int  DATA_W = 8,
    parameter int  CNT_W  = 16,
    // Smallest r with 2^r >= DATA_W + r + 1, covering the legal DATA_W range 4..57.
    localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 : 6,
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic [CODE_W-1:0] inj_mask,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err_single,
    output logic              out_err_double,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
);

    // Highest legal error position; any larger syndrome cannot be a single-bit error.
    localparam logic [PAR_W-1:0] MAX_POS = PAR_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Mask of codeword positions whose index has bit b set (positions 1..CODE_W-1).
    function automatic logic [CODE_W-1:0] syn_mask(input int b);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (((p >> b) & 1) == 1) begin
                m = m | (CODE_W'(1) << p);
            end
        end
        return m;
    endfunction

    // Codeword position of data bit j: the j-th non-power-of-two position, starting at 3.
    function automatic int data_pos(input int j);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) begin
                    pos = p;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    // ------------------------------------------------------------------
    // Front end: optional fault injection, syndrome and overall parity
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] code_in;

`ifdef HAMMING_ERR_INJECT_EN
    assign code_in = in_code ^ inj_mask;
`else
    assign code_in = in_code;
`endif

    logic [PAR_W-1:0]  syn_c;
    logic              par_c;
    logic [DATA_W-1:0] raw_data_c;

    for (genvar b = 0; b < PAR_W; b++) begin : g_syn
        localparam logic [CODE_W-1:0] MASK = syn_mask(b);
        assign syn_c[b] = ^(code_in & MASK);
    end

    // Parity over every bit including bit 0: a clean word has even overall parity.
    assign par_c = ^code_in;

    // Only the data positions travel past S1; the check bits are fully consumed by syn_c/par_c.
    for (genvar j = 0; j < DATA_W; j++) begin : g_raw
        localparam int POS = data_pos(j);
        assign raw_data_c[j] = code_in[POS];
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic s1_vld_q, s1_vld_d;
    logic out_vld_q, out_vld_d;
    logic s2_can_load;
    logic accept;

    assign s2_can_load = !out_vld_q || out_ready;
    assign in_ready    = rst_n && (!s1_vld_q || s2_can_load);
    assign accept      = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: data bits, syndrome and parity of the accepted codeword
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [PAR_W-1:0]  s1_syn_q,  s1_syn_d;
    logic              s1_par_q,  s1_par_d;

    // S1 loads on acceptance, otherwise empties when its word moves into S2.
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_data_d = s1_data_q;
        s1_syn_d  = s1_syn_q;
        s1_par_d  = s1_par_q;
        if (accept) begin
            s1_vld_d  = 1'b1;
            s1_data_d = raw_data_c;
            s1_syn_d  = syn_c;
            s1_par_d  = par_c;
        end else if (s2_can_load) begin
            s1_vld_d  = 1'b0;
        end
    end

    // S1 state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_syn_q  <= '0;
            s1_par_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            s1_syn_q  <= s1_syn_d;
            s1_par_q  <= s1_par_d;
        end
    end

    // ------------------------------------------------------------------
    // Classification and correction of the S1 word
    // ------------------------------------------------------------------
    logic              syn_nz;
    logic              syn_in_rng;
    logic              flip_en;
    logic              single_c;
    logic              double_c;
    logic [DATA_W-1:0] corr_data_c;

    assign syn_nz     = |s1_syn_q;
    assign syn_in_rng = (s1_syn_q <= MAX_POS);

    // Odd parity means an odd number of flips; with a legal syndrome that is one correctable bit
    // (syndrome 0 means bit 0 itself flipped). Even parity with a nonzero syndrome, or a syndrome
    // pointing past the codeword, cannot be repaired.
    assign flip_en  = s1_par_q && syn_nz && syn_in_rng;
    assign single_c = s1_par_q && (!syn_nz || syn_in_rng);
    assign double_c = (syn_nz && !s1_par_q) || (s1_par_q && syn_nz && !syn_in_rng);

    for (genvar j = 0; j < DATA_W; j++) begin : g_corr
        localparam int POS = data_pos(j);
        assign corr_data_c[j] = s1_data_q[j] ^ (flip_en && (s1_syn_q == PAR_W'(POS)));
    end

    // ------------------------------------------------------------------
    // Stage 2: output register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] out_dat_q, out_dat_d;
    logic              out_sgl_q, out_sgl_d;
    logic              out_dbl_q, out_dbl_d;
    logic [PAR_W-1:0]  out_syn_q, out_syn_d;

    // S2 takes the S1 word when empty or drained; payload holds otherwise so a stall is stable.
    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_sgl_d = out_sgl_q;
        out_dbl_d = out_dbl_q;
        out_syn_d = out_syn_q;
        if (s2_can_load) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out_dat_d = corr_data_c;
                out_sgl_d = single_c;
                out_dbl_d = double_c;
                out_syn_d = s1_syn_q;
            end
        end
    end

    // S2 state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_sgl_q <= 1'b0;
            out_dbl_q <= 1'b0;
            out_syn_q <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_sgl_q <= out_sgl_d;
            out_dbl_q <= out_dbl_d;
            out_syn_q <= out_syn_d;
        end
    end

    assign out_valid      = out_vld_q;
    assign out_data       = out_dat_q;
    assign out_err_single = out_sgl_q;
    assign out_err_double = out_dbl_q;
    assign out_syndrome   = out_syn_q;

    // ------------------------------------------------------------------
    // Error-event counters
    // ------------------------------------------------------------------
    logic             out_hs;
    logic [CNT_W-1:0] cnt_sgl_q, cnt_sgl_d;
    logic [CNT_W-1:0] cnt_dbl_q, cnt_dbl_d;

    // A word is counted once, when the consumer actually takes it.
    assign out_hs = out_vld_q && out_ready;

    // Saturating increment on a flagged handshake; a clear request overrides any increment.
    always_comb begin
        cnt_sgl_d = cnt_sgl_q;
        cnt_dbl_d = cnt_dbl_q;
        if (clr_cnt) begin
            cnt_sgl_d = '0;
            cnt_dbl_d = '0;
        end else if (out_hs) begin
            if (out_sgl_q && (cnt_sgl_q != CNT_MAX)) begin
                cnt_sgl_d = cnt_sgl_q + 1'b1;
            end
            if (out_dbl_q && (cnt_dbl_q != CNT_MAX)) begin
                cnt_dbl_d = cnt_dbl_q + 1'b1;
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_sgl_q <= '0;
            cnt_dbl_q <= '0;
        end else begin
            cnt_sgl_q <= cnt_sgl_d;
            cnt_dbl_q <= cnt_dbl_d;
        end
    end

    assign cnt_single = cnt_sgl_q;
    assign cnt_double = cnt_dbl_q;

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Scoreboard bench for hamming_secded_dec_pipe at DATA_W=8 (CODE_W=13, PAR_W=4).
// Stimulus pushes hand-computed expectations; a negedge monitor pops on each output handshake.
// Also covers stall stability, counter saturation, clear priority and reset mid-flight.
module tb_hamming_secded_dec_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_err_single;
    logic        out_err_double;
    logic [3:0]  out_syndrome;
    logic        clr_cnt;
    logic [15:0] cnt_single;
    logic [15:0] cnt_double;
`ifdef HAMMING_ERR_INJECT_EN
    logic [12:0] inj_mask;
`endif

    hamming_secded_dec_pipe #(.DATA_W(8), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_code        (in_code),
`ifdef HAMMING_ERR_INJECT_EN
        .inj_mask       (inj_mask),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_err_single (out_err_single),
        .out_err_double (out_err_double),
        .out_syndrome   (out_syndrome),
        .clr_cnt        (clr_cnt),
        .cnt_single     (cnt_single),
        .cnt_double     (cnt_double)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
        logic       dd;
        logic [3:0] syn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Present one codeword until accepted; record its expected result at the accepting edge.
    task automatic send(input logic [12:0] code, input logic [7:0] d, input logic s,
                        input logic dd, input logic [3:0] syn);
        exp_t e;
        bit   rdy;
        bit   done;
        in_valid = 1'b1;
        in_code  = code;
        done     = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                e.d = d; e.s = s; e.dd = dd; e.syn = syn;
                exp_q.push_back(e);
                done = 1'b1;
            end
        end
        #1;
        if (!done) begin
            chk("send_accept", 32'(done), 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_code  = '0;
    endtask

    // Wait for every expected word to be delivered, then let the last handshake edge pass.
    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: output handshake checking and stall stability.
    exp_t       mon_e;
    bit         stall_prev = 1'b0;
    bit         saw_block  = 1'b0;
    logic [7:0] sn_d;
    logic       sn_s, sn_dd;
    logic [3:0] sn_syn;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== sn_d || out_err_single !== sn_s ||
                    out_err_double !== sn_dd || out_syndrome !== sn_syn) begin
                    errors++;
                    $display("FAIL stall_stable actual=v%0b d=0x%0h s%0b dd%0b syn%0d required=v1 d=0x%0h s%0b dd%0b syn%0d",
                             out_valid, out_data, out_err_single, out_err_double, out_syndrome,
                             sn_d, sn_s, sn_dd, sn_syn);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected actual=data 0x%0h required=no output", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_data !== mon_e.d || out_err_single !== mon_e.s ||
                        out_err_double !== mon_e.dd || out_syndrome !== mon_e.syn) begin
                        errors++;
                        $display("FAIL out_word actual=d 0x%0h s%0b dd%0b syn%0d required=d 0x%0h s%0b dd%0b syn%0d",
                                 out_data, out_err_single, out_err_double, out_syndrome,
                                 mon_e.d, mon_e.s, mon_e.dd, mon_e.syn);
                    end
                end
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            sn_d   = out_data;
            sn_s   = out_err_single;
            sn_dd  = out_err_double;
            sn_syn = out_syndrome;
            if (in_valid && !in_ready && !out_ready) saw_block = 1'b1;
        end
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog actual=still running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
`ifdef HAMMING_ERR_INJECT_EN
        inj_mask  = '0;
`endif
        #12;
        chk("rst_in_ready",   32'(in_ready), 32'd0);
        chk("rst_out_valid",  32'(out_valid), 32'd0);
        chk("rst_out_data",   32'(out_data), 32'd0);
        chk("rst_flags",      32'({out_err_single, out_err_double}), 32'd0);
        chk("rst_syndrome",   32'(out_syndrome), 32'd0);
        chk("rst_cnt",        {cnt_single, cnt_double}, 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Clean word and two-cycle latency.
        send(13'h144E, 8'hA5, 1'b0, 1'b0, 4'd0);
        idle();
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        wait_drain("t1_drain");
        chk("t1_cnt", {cnt_single, cnt_double}, 32'h0000_0000);

        // Position 5 flipped.
        send(13'h146E, 8'hA5, 1'b1, 1'b0, 4'd5);
        idle();
        wait_drain("t2_drain");
        chk("t2_cnt", {cnt_single, cnt_double}, 32'h0001_0000);

        // Positions 3 and 10 flipped: syndrome 3^10=9, even parity.
        send(13'h1046, 8'h84, 1'b0, 1'b1, 4'd9);
        idle();
        wait_drain("t3_drain");
        chk("t3_cnt", {cnt_single, cnt_double}, 32'h0001_0001);

        // Overall parity bit flipped.
        send(13'h144F, 8'hA5, 1'b1, 1'b0, 4'd0);
        idle();
        wait_drain("t4_drain");
        chk("t4_cnt", {cnt_single, cnt_double}, 32'h0002_0001);

        // Six back-to-back words with a 3-cycle output stall.
        saw_block = 1'b0;
        fork
            begin
                send(13'h0000, 8'h00, 1'b0, 1'b0, 4'd0);   // clean zero word
                send(13'h1000, 8'h00, 1'b1, 1'b0, 4'd12);  // last position flipped
                send(13'h1006, 8'h80, 1'b0, 1'b1, 4'd15);  // 1,2,12 flipped: syndrome out of range
                send(13'h0008, 8'h00, 1'b1, 1'b0, 4'd3);   // d0 flipped
                send(13'h144E, 8'hA5, 1'b0, 1'b0, 4'd0);
                send(13'h146E, 8'hA5, 1'b1, 1'b0, 4'd5);
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        chk("stall_in_ready_dropped", 32'(saw_block), 32'd1);
        wait_drain("stream_drain");
        chk("stream_cnt", {cnt_single, cnt_double}, 32'h0005_0002);

        // Plain clear.
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        chk("clr_cnt", {cnt_single, cnt_double}, 32'h0000_0000);

        // Bring cnt_single to 0xFFFE, then push past saturation.
        for (int i = 0; i < 65534; i++) send(13'h146E, 8'hA5, 1'b1, 1'b0, 4'd5);
        idle();
        wait_drain("preload_drain");
        chk("cnt_fffe", 32'(cnt_single), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) send(13'h146E, 8'hA5, 1'b1, 1'b0, 4'd5);
        idle();
        wait_drain("sat_drain");
        chk("cnt_saturated", 32'(cnt_single), 32'h0000_FFFF);
        chk("cnt_double_untouched", 32'(cnt_double), 32'd0);

        // Clear in the same cycle as a flagged handshake.
        send(13'h146E, 8'hA5, 1'b1, 1'b0, 4'd5);
        idle();
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        chk("clr_win_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        chk("clr_wins", 32'(cnt_single), 32'd0);
        chk("clr_win_delivered", 32'(exp_q.size()), 32'd0);

`ifdef HAMMING_ERR_INJECT_EN
        // Injected flip of position 5 behaves like receiving 0x146E.
        inj_mask = 13'h0020;
        send(13'h144E, 8'hA5, 1'b1, 1'b0, 4'd5);
        idle();
        inj_mask = '0;
        wait_drain("inject_drain");
        chk("inject_cnt", 32'(cnt_single), 32'd1);
`endif

        // Reset while a word is in flight: it is discarded and outputs clear at once.
        send(13'h144E, 8'hA5, 1'b0, 1'b0, 4'd0);
        idle();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_cnt", {cnt_single, cnt_double}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_discarded", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
